song_sequencer: RTL and testbench

Upstream note source for the buzzer stage in auto-play modes. Walks a song stored in an external note ROM, and drives the buzzer's `note` and `octave_auto` inputs for the programmed duration of each entry. It inserts a silent gap between entries, supports pause, stop and song select, and signals completion. All timing is derived from a single system clock.

---
 rtl/song_sequencer_if.sv | 28 ++
 rtl/song_sequencer.sv | 154 +++++++++++++++
 tb/tb_song_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Sequencer bus: playback controls from the host, note/status outputs to the
// buzzer stage, and the combinational note-ROM port.
interface song_sequencer_if #(
   parameter int ADDR_W = 6,
   parameter int IDX_W  = 4
);
   logic              start;
   logic              stop;
   logic              pause;
   logic [1:0]        song_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [8:0]        rom_data;
   logic [3:0]        note;
   logic [1:0]        octave_auto;
   logic              playing;
   logic              done;
   logic [IDX_W-1:0]  note_idx;

   modport master (
      output start, stop, pause, song_sel, rom_data,
      input  rom_addr, note, octave_auto, playing, done, note_idx
   );

   modport slave (
      input  start, stop, pause, song_sel, rom_data,
      output rom_addr, note, octave_auto, playing, done, note_idx
   );
endinterface

// File: rtl/song_sequencer.sv
// Walks one song of a combinational note ROM and feeds note/octave to the
// buzzer, with a silent gap after each entry, pause, stop and end detection.
module song_sequencer #(
   parameter int unsigned BEAT_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES  = 2_500_000,
   parameter int unsigned SONG_DEPTH  = 16,
   parameter int unsigned ADDR_W      = 6,
   localparam int unsigned IDX_W      = $clog2(SONG_DEPTH)
) (
   input logic             clk,
   input logic             rst,
   song_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_e;

   localparam bit          HAS_GAP  = (GAP_CYCLES != 0);
   localparam logic [31:0] GAP_LOAD = HAS_GAP ? 32'(GAP_CYCLES - 1) : 32'd0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_DEPTH - 1);

   state_e            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        nlat_q, nlat_d;
   logic [3:0]        note_q, note_d;
   logic [1:0]        oct_q, oct_d;
   logic              playing_q, playing_d;
   logic              done_q, done_d;

   logic              frozen;
   logic              advance;
   logic [3:0]        rom_note;
   logic [1:0]        rom_oct;
   logic [2:0]        rom_beats;

   assign rom_note  = bus.rom_data[3:0];
   assign rom_oct   = bus.rom_data[5:4];
   assign rom_beats = bus.rom_data[8:6];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      nlat_d  = nlat_q;
      oct_d   = oct_q;
      frozen  = 1'b0;
      advance = 1'b0;

      if (bus.stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  addr_d  = ADDR_W'(32'(bus.song_sel) * SONG_DEPTH);
                  idx_d   = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (rom_beats == 3'd0) begin
                  state_d = S_DONE;
               end else begin
                  // Only notes 0..7 are playable; anything higher plays as a rest.
                  nlat_d  = (rom_note > 4'd7) ? 4'd0 : rom_note;
                  oct_d   = rom_oct;
                  cnt_d   = 32'(rom_beats) * BEAT_CYCLES - 32'd1;
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               if (bus.pause) begin
                  frozen = 1'b1;
               end else if (cnt_q == 32'd0) begin
                  if (HAS_GAP) begin
                     cnt_d   = GAP_LOAD;
                     state_d = S_GAP;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            S_GAP: begin
               if (bus.pause) begin
                  frozen = 1'b1;
               end else if (cnt_q == 32'd0) begin
                  advance = 1'b1;
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase

         if (advance) begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_LOAD;
            end
         end
      end

      // Outputs are registered, so they are decoded from the next state.
      note_d    = (state_d == S_PLAY && !frozen) ? nlat_d : 4'd0;
      playing_d = (state_d == S_LOAD) || (state_d == S_PLAY) || (state_d == S_GAP);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         nlat_q    <= '0;
         note_q    <= '0;
         oct_q     <= '0;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         nlat_q    <= nlat_d;
         note_q    <= note_d;
         oct_q     <= oct_d;
         playing_q <= playing_d;
         done_q    <= done_d;
      end
   end

   assign bus.rom_addr    = addr_q;
   assign bus.note_idx    = idx_q;
   assign bus.note        = note_q;
   assign bus.octave_auto = oct_q;
   assign bus.playing     = playing_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: each song run pushes its expected per-cycle output frames,
// which are popped and compared one per clock as the sequencer plays.
module tb_song_sequencer;

   localparam int BEAT = 4;
   localparam int GAP  = 2;

   typedef struct packed {
      logic [3:0] note;
      logic [1:0] oct;
      logic       play;
      logic       done;
      logic [5:0] addr;
      logic [3:0] idx;
   } frame_t;

   logic clk = 1'b0;
   logic rst;
   logic [8:0] rom [64];

   song_sequencer_if #(.ADDR_W(6), .IDX_W(4)) bus ();

   song_sequencer #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES (GAP),
      .SONG_DEPTH (16),
      .ADDR_W     (6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.rom_data = rom[bus.rom_addr];

   int     n_cmp = 0;
   int     n_err = 0;
   frame_t tl[$];
   frame_t sb[$];
   logic [1:0] m_oct;
   logic [5:0] m_addr;
   logic [3:0] m_idx;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] w(input int n, input int o, input int b);
      return {3'(b), 2'(o), 4'(n)};
   endfunction

   function automatic frame_t fr(input logic [3:0] n, input logic pl, input logic dn);
      frame_t f;
      f.note = n; f.oct = m_oct; f.play = pl; f.done = dn;
      f.addr = m_addr; f.idx = m_idx;
      return f;
   endfunction

   // Expected timeline from the first LOAD cycle to the IDLE cycle after DONE.
   task automatic build_song(input int sel);
      logic [8:0] wd;
      logic [3:0] n;
      tl.delete();
      for (int i = 0; i < 16; i++) begin
         wd     = rom[sel*16 + i];
         m_addr = 6'(sel*16 + i);
         m_idx  = 4'(i);
         tl.push_back(fr(4'd0, 1'b1, 1'b0));
         if (wd[8:6] == 3'd0) begin
            tl.push_back(fr(4'd0, 1'b0, 1'b1));
            tl.push_back(fr(4'd0, 1'b0, 1'b0));
            return;
         end
         m_oct = wd[5:4];
         n     = (wd[3:0] > 4'd7) ? 4'd0 : wd[3:0];
         for (int k = 0; k < int'(wd[8:6]) * BEAT; k++) tl.push_back(fr(n, 1'b1, 1'b0));
         for (int k = 0; k < GAP; k++) tl.push_back(fr(4'd0, 1'b1, 1'b0));
      end
      tl.push_back(fr(4'd0, 1'b0, 1'b1));
      tl.push_back(fr(4'd0, 1'b0, 1'b0));
   endtask

   // Pause sampled in cycles lo..hi: everything from cycle lo+1 shifts later,
   // and the frozen cycles show the paused state with a silent note.
   task automatic add_pause(input int lo, input int hi);
      frame_t f;
      f = tl[lo-1];
      f.note = 4'd0;
      for (int k = lo; k <= hi; k++) tl.insert(lo, f);
   endtask

   task automatic add_abort(input int at, input bit is_rst);
      frame_t f;
      while (tl.size() > at) void'(tl.pop_back());
      f = tl[at-1];
      if (is_rst) begin
         f = '0;
      end else begin
         f.note = 4'd0; f.play = 1'b0; f.done = 1'b0;
      end
      m_oct = f.oct; m_addr = f.addr; m_idx = f.idx;
      tl.push_back(f);
      tl.push_back(f);
   endtask

   task automatic cmp_frame(input int c, input frame_t e);
      chk($sformatf("note c%0d", c),    bus.note,        e.note);
      chk($sformatf("octave c%0d", c),  bus.octave_auto, e.oct);
      chk($sformatf("playing c%0d", c), bus.playing,     e.play);
      chk($sformatf("done c%0d", c),    bus.done,        e.done);
      chk($sformatf("rom_addr c%0d", c), bus.rom_addr,   e.addr);
      chk($sformatf("note_idx c%0d", c), bus.note_idx,   e.idx);
   endtask

   // Cycle 0 is the start cycle; sb[0] is the expectation for cycle 1 (LOAD).
   task automatic run(input logic [1:0] sel, input int p_lo, input int p_hi,
                      input int s_lo, input int s_hi, input int ab_at, input bit ab_rst);
      int c;
      foreach (tl[i]) sb.push_back(tl[i]);
      c = 0;
      bus.song_sel = sel;
      bus.start    = 1'b1;
      while (sb.size() != 0 && c < 400) begin
         @(posedge clk); #1;
         c++;
         bus.start    = (c >= s_lo && c <= s_hi);
         bus.song_sel = 2'($urandom);
         bus.pause    = (c >= p_lo && c <= p_hi);
         bus.stop     = (c == ab_at) && !ab_rst;
         rst          = (c == ab_at) && ab_rst;
         cmp_frame(c, sb.pop_front());
      end
      bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; rst = 1'b0;
      chk("drain", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      foreach (rom[i]) rom[i] = 9'd0;
      rom[0]  = w(5, 2, 2);
      rom[1]  = w(1, 1, 1);
      rom[16] = w(9, 1, 1);
      rom[17] = w(3, 2, 2);
      for (int i = 0; i < 16; i++) rom[32+i] = w(i % 8, i % 4, 1);
      rom[48] = w(7, 3, 3);
      rom[49] = w(2, 0, 1);

      bus.start = 1'b1; bus.stop = 1'b0; bus.pause = 1'b0; bus.song_sel = 2'd0;
      rst = 1'b1;
      m_oct = '0; m_addr = '0; m_idx = '0;

      // Reset held with start high: stays idle with all outputs zero.
      for (int k = 0; k < 3; k++) sb.push_back('0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         cmp_frame(-3 + k, sb.pop_front());
      end
      rst = 1'b0;

      build_song(0);
      run(2'd0, 0, -1, 0, -1, -1, 1'b0);

      build_song(0);
      add_pause(3, 6);
      run(2'd0, 3, 6, 0, -1, -1, 1'b0);

      build_song(0);
      add_abort(6, 1'b0);
      run(2'd0, 0, -1, 0, -1, 6, 1'b0);

      build_song(1);
      run(2'd1, 0, -1, 3, 12, -1, 1'b0);

      build_song(2);
      add_pause(20, 21);
      run(2'd2, 20, 21, 0, -1, -1, 1'b0);

      build_song(3);
      add_abort(4, 1'b1);
      run(2'd3, 0, -1, 0, -1, 4, 1'b1);

      build_song(0);
      run(2'd0, 0, -1, 0, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
